// File: rtl/s2p_pkg.sv
// Shared definitions for the receive-side serial-to-parallel path:
// FSM encodings live here so every user agrees on them.
package s2p_pkg;

  localparam logic HUNT    = 1'b0;
  localparam logic COLLECT = 1'b1;

  typedef enum logic {
    STATE_HUNT    = HUNT,
    STATE_COLLECT = COLLECT
  } s2p_state_t;

  function automatic int unsigned s2p_count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/s2p_hold_buf.sv
// One-entry valid/ready holding register. A new word is dropped, with an
// overrun pulse, when the held word is still pending and not taken this cycle.
module s2p_hold_buf #(
  parameter int WIDTH = 2
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  // Handshake: a word moves when valid && ready on a rising edge; data is
  // held stable while valid is high and ready is low.
  logic accept;
  logic can_load;

  assign accept   = valid && ready;
  assign can_load = !valid || ready;

  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load_valid) begin
        if (can_load) begin
          data  <= load_data;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial2parallel.sv
// Collects an MSB-first qualified bit stream into WIDTH-bit words framed by
// an alignment strobe, and hands each word to a one-entry output buffer.
module serial2parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             serial_sig,
  input  logic             serial_valid,
  input  logic             align_sig,
  output logic [WIDTH-1:0] parallel_sig,
  output logic             parallel_valid,
  input  logic             parallel_ready,
  output logic             overrun_sig,
  output logic             misalign_sig,
  output s2p_state_t       state_dbg
);

  localparam int CW = s2p_count_width(WIDTH);

  s2p_state_t       state, state_next;
  logic [WIDTH-1:0] shift_q, shift_next;
  logic [CW-1:0]    count_q, count_next;
  logic             misalign_next;
  logic             word_done;
  logic [WIDTH-1:0] word_data;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] new_shift;
  logic [CW-1:0]    new_count;
  logic             take_bit;
  logic             restart;

  assign state_dbg = state;

  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      state        <= STATE_HUNT;
      shift_q      <= '0;
      count_q      <= '0;
      misalign_sig <= 1'b0;
    end else begin
      state        <= state_next;
      shift_q      <= shift_next;
      count_q      <= count_next;
      misalign_sig <= misalign_next;
    end
  end

  // A bit starts a fresh word when it carries align or follows a completed
  // word; in HUNT only an aligned bit is taken at all.
  always_comb begin
    state_next    = state;
    shift_next    = shift_q;
    count_next    = count_q;
    misalign_next = 1'b0;
    word_done     = 1'b0;
    word_data     = '0;
    take_bit      = serial_valid && (state == STATE_COLLECT || align_sig);
    restart       = align_sig || (count_q == '0);
    base          = restart ? '0 : shift_q;
    new_shift     = (base << 1) | WIDTH'(serial_sig);
    new_count     = (align_sig ? '0 : count_q) + CW'(1);

    if (take_bit) begin
      state_next    = STATE_COLLECT;
      misalign_next = (state == STATE_COLLECT) && align_sig && (count_q != '0);
      if (new_count == CW'(WIDTH)) begin
        word_done  = 1'b1;
        word_data  = new_shift;
        shift_next = '0;
        count_next = '0;
      end else begin
        shift_next = new_shift;
        count_next = new_count;
      end
    end
  end

  s2p_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clk_sig   (clk_sig),
    .reset_sig (reset_sig),
    .load_valid(word_done),
    .load_data (word_data),
    .data      (parallel_sig),
    .valid     (parallel_valid),
    .ready     (parallel_ready),
    .overrun   (overrun_sig)
  );

endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench for serial2parallel at WIDTH=4, 2 and 1 sharing one
// input stream; each phase checks only the instance it targets.
module tb_serial2parallel;
  import s2p_pkg::*;

  logic clk_sig = 1'b0;
  logic reset_sig;
  logic serial_sig, serial_valid, align_sig, parallel_ready;

  logic [3:0] p4;
  logic       v4, o4, m4;
  s2p_state_t s4;
  logic [1:0] p2;
  logic       v2, o2, m2;
  s2p_state_t s2;
  logic [0:0] p1;
  logic       v1, o1, m1;
  s2p_state_t s1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sig = ~clk_sig;

  serial2parallel #(.WIDTH(4)) u_dut4 (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .serial_sig(serial_sig),
    .serial_valid(serial_valid), .align_sig(align_sig), .parallel_sig(p4),
    .parallel_valid(v4), .parallel_ready(parallel_ready), .overrun_sig(o4),
    .misalign_sig(m4), .state_dbg(s4));

  serial2parallel #(.WIDTH(2)) u_dut2 (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .serial_sig(serial_sig),
    .serial_valid(serial_valid), .align_sig(align_sig), .parallel_sig(p2),
    .parallel_valid(v2), .parallel_ready(parallel_ready), .overrun_sig(o2),
    .misalign_sig(m2), .state_dbg(s2));

  serial2parallel #(.WIDTH(1)) u_dut1 (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .serial_sig(serial_sig),
    .serial_valid(serial_valid), .align_sig(align_sig), .parallel_sig(p1),
    .parallel_valid(v1), .parallel_ready(parallel_ready), .overrun_sig(o1),
    .misalign_sig(m1), .state_dbg(s1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic step(input logic s, input logic v, input logic a);
    serial_sig   = s;
    serial_valid = v;
    align_sig    = a;
    @(posedge clk_sig);
    #1;
  endtask

  task automatic do_reset();
    reset_sig = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset_sig = 1'b0;
  endtask

  logic [11:0] stream;

  initial begin
    reset_sig      = 1'b0;
    serial_sig     = 1'b0;
    serial_valid   = 1'b0;
    align_sig      = 1'b0;
    parallel_ready = 1'b1;
    #2;

    // Reset state
    do_reset();
    chk("rst_data", 32'(p4), 32'h0);
    chk("rst_valid", 32'(v4), 32'h0);
    chk("rst_overrun", 32'(o4), 32'h0);
    chk("rst_misalign", 32'(m4), 32'h0);
    chk("rst_state", 32'(s4), 32'(HUNT));

    // Basic alignment: 1,0,1,1 -> 4'b1011
    step(1, 1, 1);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("basic_not_yet", 32'(v4), 32'h0);
    step(1, 1, 0);
    chk("basic_valid", 32'(v4), 32'h1);
    chk("basic_data", 32'(p4), 32'hB);
    step(0, 0, 0);
    chk("basic_consumed", 32'(v4), 32'h0);

    // Hunt: unaligned bits discarded, then 0,1,1,0 -> 4'b0110
    do_reset();
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("hunt_state", 32'(s4), 32'(HUNT));
    chk("hunt_no_word", 32'(v4), 32'h0);
    step(0, 1, 1);
    chk("hunt_collect", 32'(s4), 32'(COLLECT));
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    chk("hunt_valid", 32'(v4), 32'h1);
    chk("hunt_data", 32'(p4), 32'h6);

    // Continuous stream A, 3, F with one align
    do_reset();
    stream = 12'hA3F;
    for (int i = 0; i < 12; i++) begin
      step(stream[11-i], 1'b1, (i == 0));
      if (i % 4 == 3) begin
        chk($sformatf("stream_valid%0d", i), 32'(v4), 32'h1);
        chk($sformatf("stream_data%0d", i), 32'(p4), 32'(stream[11-(i-3) -: 4]));
      end else if (i == 4 || i == 8) begin
        chk($sformatf("stream_gap%0d", i), 32'(v4), 32'h0);
      end
    end

    // Backpressure and overrun at WIDTH=2: 10 held, 01 dropped
    parallel_ready = 1'b0;
    do_reset();
    step(1, 1, 1);
    step(0, 1, 0);
    chk("bp_valid", 32'(v2), 32'h1);
    chk("bp_data", 32'(p2), 32'h2);
    chk("bp_no_overrun", 32'(o2), 32'h0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("bp_overrun", 32'(o2), 32'h1);
    chk("bp_data_held", 32'(p2), 32'h2);
    step(0, 0, 0);
    chk("bp_overrun_pulse", 32'(o2), 32'h0);
    chk("bp_still_valid", 32'(v2), 32'h1);
    chk("bp_still_data", 32'(p2), 32'h2);
    parallel_ready = 1'b1;
    step(0, 0, 0);
    chk("bp_drained", 32'(v2), 32'h0);

    // Misalign: two bits, then align with 1,1,0,0
    do_reset();
    step(1, 1, 1);
    step(0, 1, 0);
    chk("mis_quiet", 32'(m4), 32'h0);
    step(1, 1, 1);
    chk("mis_pulse", 32'(m4), 32'h1);
    step(1, 1, 0);
    chk("mis_pulse_end", 32'(m4), 32'h0);
    step(0, 1, 0);
    chk("mis_no_word", 32'(v4), 32'h0);
    step(0, 1, 0);
    chk("mis_valid", 32'(v4), 32'h1);
    chk("mis_data", 32'(p4), 32'hC);

    // Mid-operation reset with pending word and partial word
    parallel_ready = 1'b0;
    do_reset();
    step(1, 1, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("mr_pending", 32'(v4), 32'h1);
    chk("mr_pending_data", 32'(p4), 32'h9);
    reset_sig = 1'b1;
    step(1, 1, 1);
    reset_sig = 1'b0;
    chk("mr_data", 32'(p4), 32'h0);
    chk("mr_valid", 32'(v4), 32'h0);
    chk("mr_state", 32'(s4), 32'(HUNT));
    parallel_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'(i & 1), 1'b1, 1'b0);
      chk($sformatf("mr_unaligned%0d", i), 32'(v4), 32'h0);
    end

    // WIDTH=1: every aligned-onward bit is a word
    do_reset();
    step(1, 1, 1);
    chk("w1_valid_a", 32'(v1), 32'h1);
    chk("w1_data_a", 32'(p1), 32'h1);
    step(0, 1, 0);
    chk("w1_valid_b", 32'(v1), 32'h1);
    chk("w1_data_b", 32'(p1), 32'h0);
    step(0, 0, 0);
    chk("w1_drained", 32'(v1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial2parallel.md
# serial2parallel

Serial-to-parallel converter for the BPSK/ConvCode datapath, the receive-side counterpart of `parallel2serial`. It collects a qualified MSB-first bit stream into WIDTH-bit words. Word boundaries are set by an alignment strobe. Each completed word is presented on a valid/ready output with a one-word holding register. It sits after bit slicing / hard decision and feeds the convolutional decoder or any block consuming WIDTH-bit symbols.

## Interface
- `WIDTH`, 2, bits per parallel word (≥1).
- `clk_sig`  in  1  single clock; all state changes on its rising edge.
- `reset_sig`  in  1  reset, synchronous, active-high.
- `serial_sig`  in  1  serial data bit; sampled only when `serial_valid`=1.
- `serial_valid`  in  1  bit strobe; one bit consumed per cycle it is high.
- `align_sig`  in  1  marks the current valid bit as the MSB of a new word; ignored when `serial_valid`=0.
- `parallel_sig`  out  WIDTH  assembled word; first received bit is at [WIDTH-1].
- `parallel_valid`  out  1  `parallel_sig` holds an unconsumed word.
- `parallel_ready`  in  1  consumer accepts the word when high together with `parallel_valid`.
- `overrun_sig`  out  1  one-cycle pulse: a completed word was dropped because the holding register was full.
- `misalign_sig`  out  1  one-cycle pulse: `align_sig` arrived mid-word and the partial word was discarded.

## Operation
- Bit order matches `parallel2serial`: MSB first, so shift left and insert the new bit at [0].
- State `HUNT` (reset state): valid bits without `align_sig` are discarded. A valid bit with `align_sig` becomes bit 1 of a word, and the state moves to `COLLECT`.
- State `COLLECT`: each valid bit is shifted in and the bit count increments. When the count reaches WIDTH, the word completes and the count returns to 0. The state stays `COLLECT`, and the next valid bit is the MSB of the next word; no further `align_sig` is required.
- `align_sig` in `COLLECT` with count = 0 is consistent framing. No error is raised.
- `align_sig` in `COLLECT` with count ≠ 0 is handled as follows:
  - the partial word is dropped;
  - this bit becomes bit 1 of the new word;
  - `misalign_sig` pulses.
- Word completion with the holding register empty, or consumed in the same cycle: load the word and set or keep `parallel_valid`=1.
- Word completion with the holding register full and not consumed: the new word is dropped, the held word is kept unchanged, and `overrun_sig` pulses.
- Handshake: while `parallel_valid`=1 and `parallel_ready`=0, `parallel_sig` is stable. `parallel_valid` clears after a ready cycle if no new word loads in that same cycle.
- WIDTH=1: every valid bit after alignment completes a word.
- Bit count width: `$clog2(WIDTH+1)`.

## Timing
- Reset values:
  - `parallel_sig`=0, `parallel_valid`=0, `overrun_sig`=0, `misalign_sig`=0;
  - state `HUNT`, bit count 0, shift register 0.
- Reset has priority over all inputs, including a mid-word or a pending output word. Everything in flight is discarded.
- Latency: if the last bit of a word is valid in cycle N, `parallel_valid`/`parallel_sig` update at the edge ending cycle N and are visible in cycle N+1.
- Throughput: one word per WIDTH valid bits. `serial_valid` may be tied high, giving back-to-back words every WIDTH cycles.
- Pulses on `overrun_sig` and `misalign_sig` are registered and aligned with cycle N+1 of the causing bit.
- Simultaneous `align_sig` mid-word and completion cannot occur: a completing bit always has count = WIDTH-1 and no align, otherwise misalign rules apply.

## Structure
- The state encodings (`HUNT`, `COLLECT`) go as localparams in the shared common package/header used by `rtl/common`, so the receive-side FSM encodings live in one place.
- One natural sub-module is `s2p_hold_buf`, the one-entry valid/ready holding register with drop/overrun logic. The FSM, shift register and bit counter stay in `serial2parallel`.
- The free-running `counter` is not reused, because it cannot be gated by `serial_valid` or reset by `align_sig`.

## Test plan
- Basic alignment (WIDTH=4, ready=1, valid=1): align on the first bit, stream 1,0,1,1 → `parallel_sig`=4'b1011, `parallel_valid` high one cycle after the 4th bit.
- Hunt: 3 valid bits with no align, then align+bits 0,1,1,0 → first output 4'b0110. The earlier bits are not present in any word.
- Continuous stream (WIDTH=4): a single align, then 12 bits from `parallel2serial` fed 4'hA, 4'h3, 4'hF → outputs A, 3, F on three consecutive words, 4 cycles apart.
- Backpressure and overrun (WIDTH=2): ready=0, send two full words 2'b10, 2'b01 → held word stays 2'b10, `overrun_sig` pulses once. Then ready=1 → 2'b10 consumed and `parallel_valid` drops.
- Misalign (WIDTH=4): after 2 bits, assert align with bits 1,1,0,0 → `misalign_sig` pulses one cycle, output 4'b1100.
- Mid-operation reset: assert reset while `parallel_valid`=1 with 2 bits of the next word collected → next cycle all outputs 0, state `HUNT`. Subsequent unaligned bits produce no word.
